ex_mem: RTL and testbench

EX_MEM -- requirements
Module: ex_mem

---
 rtl/ex_mem_pkg.sv | 57 +++++
 rtl/ex_mem.sv | 122 ++++++++++++
 tb/tb_ex_mem.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_pkg.sv
// Shared definitions for the EX/MEM pipeline register: stall bit positions,
// constants, aluop encodings, multi-cycle step counts and the slot record.
package ex_mem_pkg;

  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  localparam logic [7:0] ALUOP_NOP   = 8'h00;
  localparam logic [7:0] ALUOP_MADD  = 8'hA6;
  localparam logic [7:0] ALUOP_MADDU = 8'hA8;
  localparam logic [7:0] ALUOP_MSUB  = 8'hAA;
  localparam logic [7:0] ALUOP_MSUBU = 8'hAB;
  localparam logic [7:0] ALUOP_LW    = 8'hE3;
  localparam logic [7:0] ALUOP_SW    = 8'hEB;

  // MADD/MSUB step count values carried between EX and the carry register
  localparam logic [1:0] CNT_IDLE  = 2'd0;
  localparam logic [1:0] CNT_STEP1 = 2'd1;

  typedef enum logic [1:0] {
    ACT_FLUSH   = 2'd0,
    ACT_BUBBLE  = 2'd1,
    ACT_ADVANCE = 2'd2,
    ACT_HOLD    = 2'd3
  } act_e;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic [7:0]  aluop;
    logic [31:0] mem_addr;
    logic [31:0] reg2;
    logic        valid;
  } mem_slot_t;

  function automatic act_e sel_action(input logic flush, input logic ex_stall,
                                      input logic mem_stall);
    act_e act;
    if (flush) begin
      act = ACT_FLUSH;
    end else if (!ex_stall) begin
      act = ACT_ADVANCE;
    end else if (!mem_stall) begin
      act = ACT_BUBBLE;
    end else begin
      act = ACT_HOLD;
    end
    return act;
  endfunction

endpackage

// File: rtl/ex_mem.sv
// EX/MEM pipeline register with flush/bubble/advance/hold control and the
// partial-product carry register used by two-step MADD/MSUB.
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int CNT_W   = 2,
  parameter int STALL_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [4:0]         ex_wd,
  input  logic               ex_wreg,
  input  logic [31:0]        ex_wdata,
  input  logic [31:0]        ex_hi,
  input  logic [31:0]        ex_lo,
  input  logic               ex_whilo,
  input  logic [7:0]         ex_aluop,
  input  logic [31:0]        ex_mem_addr,
  input  logic [31:0]        ex_reg2,
  input  logic [63:0]        hilo_i,
  input  logic [CNT_W-1:0]   cnt_i,
  output logic [4:0]         mem_wd,
  output logic               mem_wreg,
  output logic [31:0]        mem_wdata,
  output logic [31:0]        mem_hi,
  output logic [31:0]        mem_lo,
  output logic               mem_whilo,
  output logic [7:0]         mem_aluop,
  output logic [31:0]        mem_mem_addr,
  output logic [31:0]        mem_reg2,
  output logic               mem_valid,
  output logic [63:0]        hilo_o,
  output logic [CNT_W-1:0]   cnt_o
);

  // Masks read the whole stall vector so the unused bits drop out cleanly.
  localparam logic [STALL_W-1:0] EX_MASK  = STALL_W'(1) << STALL_EX;
  localparam logic [STALL_W-1:0] MEM_MASK = STALL_W'(1) << STALL_MEM;

  logic       ex_stall_s;
  logic       mem_stall_s;
  act_e       act_s;
  mem_slot_t  slot_d, slot_q;
  logic [63:0]      hilo_d, hilo_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  assign ex_stall_s  = |(stall & EX_MASK);
  assign mem_stall_s = |(stall & MEM_MASK);
  assign act_s       = sel_action(flush, ex_stall_s, mem_stall_s);

  // Next-state selection for the slot and the carry register
  always_comb begin
    slot_d = slot_q;
    hilo_d = hilo_q;
    cnt_d  = cnt_q;
    case (act_s)
      ACT_FLUSH: begin
        slot_d = '0;
        hilo_d = {ZERO_WORD, ZERO_WORD};
        cnt_d  = CNT_W'(CNT_IDLE);
      end
      ACT_BUBBLE: begin
        slot_d = '0;
        hilo_d = hilo_i;
        cnt_d  = cnt_i;
      end
      ACT_ADVANCE: begin
        slot_d.wd       = ex_wd;
        slot_d.wreg     = ex_wreg;
        slot_d.wdata    = ex_wdata;
        slot_d.hi       = ex_hi;
        slot_d.lo       = ex_lo;
        slot_d.whilo    = ex_whilo;
        slot_d.aluop    = ex_aluop;
        slot_d.mem_addr = ex_mem_addr;
        slot_d.reg2     = ex_reg2;
        slot_d.valid    = 1'b1;
        hilo_d          = {ZERO_WORD, ZERO_WORD};
        cnt_d           = CNT_W'(CNT_IDLE);
      end
      ACT_HOLD: begin
        slot_d = slot_q;
        hilo_d = hilo_q;
        cnt_d  = cnt_q;
      end
      default: begin
        slot_d = '0;
        hilo_d = {ZERO_WORD, ZERO_WORD};
        cnt_d  = CNT_W'(CNT_IDLE);
      end
    endcase
  end

  // Register bank and carry register, cleared asynchronously by rst
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q <= '0;
      hilo_q <= 64'h0;
      cnt_q  <= '0;
    end else begin
      slot_q <= slot_d;
      hilo_q <= hilo_d;
      cnt_q  <= cnt_d;
    end
  end

  assign mem_wd       = slot_q.wd;
  assign mem_wreg     = slot_q.wreg;
  assign mem_wdata    = slot_q.wdata;
  assign mem_hi       = slot_q.hi;
  assign mem_lo       = slot_q.lo;
  assign mem_whilo    = slot_q.whilo;
  assign mem_aluop    = slot_q.aluop;
  assign mem_mem_addr = slot_q.mem_addr;
  assign mem_reg2     = slot_q.reg2;
  assign mem_valid    = slot_q.valid;
  assign hilo_o       = hilo_q;
  assign cnt_o        = cnt_q;

endmodule

// File: tb/tb_ex_mem.sv
// Bench for ex_mem: directed vector table, hand sequences for reset and
// MADD corners, then randomized cycles against a rule-level reference model.
module tb_ex_mem;

  typedef struct packed {
    logic        flush;
    logic [5:0]  stall;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic [7:0]  aluop;
    logic [31:0] addr;
    logic [31:0] reg2;
    logic [63:0] hilo;
    logic [1:0]  cnt;
  } in_t;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic [7:0]  aluop;
    logic [31:0] addr;
    logic [31:0] reg2;
    logic        valid;
    logic [63:0] hilo;
    logic [1:0]  cnt;
  } out_t;

  typedef struct packed {
    in_t  in;
    out_t exp;
  } vec_t;

  logic clk;
  logic rst;
  in_t  cur;
  out_t act;
  out_t model;
  int   n_cmp;
  int   n_bad;

  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
  logic        mem_whilo, mem_valid;
  logic [7:0]  mem_aluop;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;

  ex_mem #(.CNT_W(2), .STALL_W(6)) dut (
    .clk(clk), .rst(rst), .stall(cur.stall), .flush(cur.flush),
    .ex_wd(cur.wd), .ex_wreg(cur.wreg), .ex_wdata(cur.wdata),
    .ex_hi(cur.hi), .ex_lo(cur.lo), .ex_whilo(cur.whilo),
    .ex_aluop(cur.aluop), .ex_mem_addr(cur.addr), .ex_reg2(cur.reg2),
    .hilo_i(cur.hilo), .cnt_i(cur.cnt),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
    .mem_valid(mem_valid), .hilo_o(hilo_o), .cnt_o(cnt_o)
  );

  assign act = {mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo,
                mem_aluop, mem_mem_addr, mem_reg2, mem_valid, hilo_o, cnt_o};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: what the MEM slot and carry register hold after one edge.
  function automatic out_t ref_next(input out_t prev, input in_t i);
    out_t o;
    o = prev;
    if (i.flush) begin
      o = '0;
    end else if (i.stall[3] == 1'b0) begin
      o = '0;
      o.wd = i.wd;  o.wreg = i.wreg;  o.wdata = i.wdata;
      o.hi = i.hi;  o.lo = i.lo;      o.whilo = i.whilo;
      o.aluop = i.aluop;  o.addr = i.addr;  o.reg2 = i.reg2;
      o.valid = 1'b1;
    end else if (i.stall[4] == 1'b0) begin
      o = '0;
      o.hilo = i.hilo;
      o.cnt  = i.cnt;
    end
    return o;
  endfunction

  task automatic chk(input string nm, input out_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step(input in_t i, input string nm, input out_t exp);
    cur = i;
    @(posedge clk);
    #1;
    chk(nm, exp);
  endtask

  function automatic in_t rand_in();
    in_t i;
    i.flush = ($urandom_range(0, 7) == 0);
    i.stall = 6'($urandom);
    i.wd = 5'($urandom);  i.wreg = 1'($urandom);  i.wdata = $urandom;
    i.hi = $urandom;  i.lo = $urandom;  i.whilo = 1'($urandom);
    i.aluop = 8'($urandom);  i.addr = $urandom;  i.reg2 = $urandom;
    i.hilo = {$urandom, $urandom};  i.cnt = 2'($urandom_range(0, 3));
    return i;
  endfunction

  vec_t tbl[13];
  in_t  t;
  out_t e;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    cur = rand_in();
    #12;
    chk("reset_state", '0);
    @(posedge clk);
    #1;
    chk("reset_held_over_edge", '0);
    rst = 1'b1;

    for (int k = 0; k < 13; k++) begin
      tbl[k] = '0;
    end
    // advance: basic capture
    tbl[0].in.wd = 5'd5;  tbl[0].in.wreg = 1'b1;  tbl[0].in.wdata = 32'h1234_5678;
    tbl[0].exp.wd = 5'd5; tbl[0].exp.wreg = 1'b1; tbl[0].exp.wdata = 32'h1234_5678;
    tbl[0].exp.valid = 1'b1;
    // bubble: MADD step 1 captures the partial product
    tbl[1].in.stall = 6'b001000;  tbl[1].in.wreg = 1'b1;  tbl[1].in.whilo = 1'b1;
    tbl[1].in.wdata = 32'h5555_0000;  tbl[1].in.aluop = 8'hA6;
    tbl[1].in.hilo = 64'h0000_0001_FFFF_FFFF;  tbl[1].in.cnt = 2'd1;
    tbl[1].exp.hilo = 64'h0000_0001_FFFF_FFFF;  tbl[1].exp.cnt = 2'd1;
    // advance: MADD step 2 writes HI/LO, carry register returns to zero
    tbl[2].in.whilo = 1'b1;  tbl[2].in.hi = 32'h0000_0002;  tbl[2].in.lo = 32'hFFFF_FFFE;
    tbl[2].in.aluop = 8'hA6;  tbl[2].in.hilo = 64'h0000_0001_FFFF_FFFF;  tbl[2].in.cnt = 2'd1;
    tbl[2].exp.whilo = 1'b1;  tbl[2].exp.hi = 32'h0000_0002;  tbl[2].exp.lo = 32'hFFFF_FFFE;
    tbl[2].exp.aluop = 8'hA6;  tbl[2].exp.valid = 1'b1;
    // advance: load AAAA_AAAA, then hold three cycles with changing ex_wdata
    tbl[3].in.wdata = 32'hAAAA_AAAA;  tbl[3].in.addr = 32'h8000_0010;  tbl[3].in.reg2 = 32'h0BAD_F00D;
    tbl[3].exp.wdata = 32'hAAAA_AAAA;  tbl[3].exp.addr = 32'h8000_0010;
    tbl[3].exp.reg2 = 32'h0BAD_F00D;  tbl[3].exp.valid = 1'b1;
    for (int k = 4; k < 7; k++) begin
      tbl[k].in.stall = 6'b011000;
      tbl[k].in.wdata = 32'h1111_1111 * k;
      tbl[k].in.hilo = 64'hFFFF_0000_FFFF_0000;  tbl[k].in.cnt = 2'd3;
      tbl[k].exp = tbl[3].exp;
    end
    // flush wins over bubble
    tbl[7].in.flush = 1'b1;  tbl[7].in.stall = 6'b001000;  tbl[7].in.wreg = 1'b1;
    tbl[7].in.hilo = 64'h1234_5678_9ABC_DEF0;  tbl[7].in.cnt = 2'd1;
    // illegal stall[4] alone treated as advance
    tbl[8].in.stall = 6'b010000;  tbl[8].in.wd = 5'd31;  tbl[8].in.wreg = 1'b1;
    tbl[8].in.hilo = 64'hFFFF_FFFF_FFFF_FFFF;  tbl[8].in.cnt = 2'd2;
    tbl[8].exp.wd = 5'd31;  tbl[8].exp.wreg = 1'b1;  tbl[8].exp.valid = 1'b1;
    // don't-care stall bits ignored
    tbl[9].in.stall = 6'b100111;  tbl[9].in.aluop = 8'hEB;  tbl[9].in.reg2 = 32'hCAFE_BABE;
    tbl[9].exp.aluop = 8'hEB;  tbl[9].exp.reg2 = 32'hCAFE_BABE;  tbl[9].exp.valid = 1'b1;
    // bubble then flush mid-MADD discards the partial product
    tbl[10].in.stall = 6'b101000;  tbl[10].in.hilo = 64'h0000_00FF_0000_0001;  tbl[10].in.cnt = 2'd1;
    tbl[10].exp.hilo = 64'h0000_00FF_0000_0001;  tbl[10].exp.cnt = 2'd1;
    tbl[11].in.flush = 1'b1;  tbl[11].in.stall = 6'b011000;  tbl[11].in.cnt = 2'd1;
    tbl[11].in.hilo = 64'h0000_00FF_0000_0001;
    // hold after flush keeps zeros
    tbl[12].in.stall = 6'b111111;  tbl[12].in.wdata = 32'hFFFF_FFFF;  tbl[12].in.cnt = 2'd3;

    for (int k = 0; k < 13; k++) begin
      step(tbl[k].in, $sformatf("vec%0d", k), tbl[k].exp);
    end

    // async reset mid-cycle with DEADBEEF in the slot
    t = '0;  t.wdata = 32'hDEAD_BEEF;  t.wreg = 1'b1;  t.hilo = 64'h5;
    e = '0;  e.wdata = 32'hDEAD_BEEF;  e.wreg = 1'b1;  e.valid = 1'b1;
    step(t, "pre_reset_load", e);
    t.stall = 6'b001000;  t.cnt = 2'd1;
    e = '0;  e.hilo = 64'h5;  e.cnt = 2'd1;
    step(t, "pre_reset_bubble", e);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_clear", '0);
    @(posedge clk);
    #1;
    chk("reset_ignores_clk", '0);
    rst = 1'b1;
    t = '0;  t.wd = 5'd9;  t.wdata = 32'h0F0F_0F0F;  t.wreg = 1'b1;
    e = '0;  e.wd = 5'd9;  e.wdata = 32'h0F0F_0F0F;  e.wreg = 1'b1;  e.valid = 1'b1;
    step(t, "post_reset_advance", e);

    // randomized cycles against the reference model
    model = e;
    for (int k = 0; k < 400; k++) begin
      t = rand_in();
      model = ref_next(model, t);
      step(t, $sformatf("rand%0d", k), model);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
